// File: rtl/dice_roll_controller.sv
// Die-face sequencer: spins while roll is held, slows down over SLOW_STEPS
// progressively longer steps after release, then settles and counts the roll.
module dice_roll_controller #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SLOW_STEPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  output logic [3:0] face,
  output logic       rolling,
  output logic       done,
  output logic [7:0] roll_count
);

  localparam int TICK_MAX = TICK_DIV * (SLOW_STEPS + 1);
  localparam int TW       = $clog2(TICK_MAX);
  localparam int SW       = $clog2(SLOW_STEPS + 1);

  typedef enum logic [1:0] {IDLE, SPIN, SLOW, DONE} state_t;

  state_t          state;
  logic            roll_q;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   step;

  logic            press;
  logic [TW-1:0]   spin_last;
  logic [TW-1:0]   slow_last;
  logic            step_last;
  logic [3:0]      face_nxt;

  assign press     = roll & ~roll_q;
  assign spin_last = TW'(TICK_DIV - 1);
  // Each deceleration step lasts one TICK_DIV period longer than the previous.
  assign slow_last = TW'(TICK_DIV * (int'(step) + 1) - 1);
  assign step_last = (step == SW'(SLOW_STEPS));
  assign face_nxt  = (face == 4'd6) ? 4'd1 : face + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      face       <= 4'd0;
      rolling    <= 1'b0;
      done       <= 1'b0;
      roll_count <= 8'd0;
      roll_q     <= 1'b0;
      tick_cnt   <= '0;
      step       <= '0;
    end else begin
      roll_q <= roll;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // Edge-detected so a button held through the settle cannot re-trigger.
          if (press) begin
            state    <= SPIN;
            rolling  <= 1'b1;
            tick_cnt <= '0;
            if (face == 4'd0)
              face <= 4'd1;
          end
        end
        SPIN: begin
          if (tick_cnt == spin_last) begin
            face     <= face_nxt;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
          if (!roll) begin
            state    <= SLOW;
            step     <= SW'(1);
            tick_cnt <= '0;
          end
        end
        SLOW: begin
          if (tick_cnt == slow_last) begin
            face     <= face_nxt;
            tick_cnt <= '0;
            if (step_last) begin
              state   <= DONE;
              rolling <= 1'b0;
              done    <= 1'b1;
            end else begin
              step <= step + SW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DONE: begin
          roll_count <= roll_count + 8'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_controller.sv
// Scoreboard bench for dice_roll_controller (TICK_DIV=4, SLOW_STEPS=3).
module tb_dice_roll_controller;
  localparam int TD = 4;
  localparam int SS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll;
  logic [3:0] face;
  logic       rolling;
  logic       done;
  logic [7:0] roll_count;

  dice_roll_controller #(.TICK_DIV(TD), .SLOW_STEPS(SS)) dut (
    .clk(clk), .reset(reset), .roll(roll), .face(face),
    .rolling(rolling), .done(done), .roll_count(roll_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] adv(input logic [3:0] f, input int n);
    int r;
    r = (f == 4'd0) ? 1 : int'(f);
    return 4'(((r - 1 + n) % 6) + 1);
  endfunction

  typedef struct {
    logic [3:0] face;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_face;
  logic [7:0] model_cnt;
  int         done_cnt = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_cnt;
  logic       done_prev = 1'b0;

  // Monitor: pops the scoreboard on every settle, checks count one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (pend) begin
        check("sb_count", roll_count, pend_cnt);
        pend = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_width", done_prev, 0);
        if (sb.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_face", face, e.face);
          pend     = 1'b1;
          pend_cnt = e.cnt;
        end
      end
      check("face_range", (face <= 4'd6), 1);
      done_prev = done;
    end
  end

  task automatic push_exp(input int h);
    exp_t e;
    model_face = adv(model_face, h / TD + SS);
    model_cnt  = model_cnt + 8'd1;
    e.face = model_face;
    e.cnt  = model_cnt;
    sb.push_back(e);
  endtask

  task automatic start_roll(input int h);
    push_exp(h);
    roll = 1'b1;
    repeat (h) @(negedge clk);
    roll = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start)
      check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    int n;
    reset      = 1'b1;
    roll       = 1'b0;
    model_face = 4'd0;
    model_cnt  = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset asserted mid-spin takes effect without a clock edge
    roll = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_reset_rolling", rolling, 1);
    roll = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_face", face, 0);
    check("rst_rolling", rolling, 0);
    check("rst_done", done, 0);
    check("rst_count", roll_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Press from reset, hold 34 cycles: release lands on face 3 mid-count
    push_exp(34);
    roll = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      check("spin_face", face, adv(4'd1, (i - 1) / TD));
      check("spin_rolling", rolling, 1);
    end
    roll = 1'b0;
    for (int j = 1; j <= 37; j++) begin
      @(negedge clk);
      check("slow_face", face, 3 + int'(j >= 9) + int'(j >= 21) + int'(j >= 37));
      check("slow_rolling", rolling, int'(j < 37));
      check("slow_done", done, int'(j == 37));
    end
    @(negedge clk);
    check("settle_done", done, 0);
    check("settle_count", roll_count, 1);
    check("settle_face", face, 6);
    check("settle_rolling", rolling, 0);
    repeat (2) @(negedge clk);

    // Re-press during SLOW and hold into IDLE: ignored, no restart
    start_roll(5);
    repeat (10) @(negedge clk);
    roll = 1'b1;
    wait_done(80);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_restart", rolling, 0);
    end
    roll = 1'b0;
    repeat (2) @(negedge clk);

    // Steer the face to 2, then apply a one-cycle pulse
    k = 0;
    for (int i = 0; i < 6; i++)
      if (adv(model_face, i + SS) == 4'd2) k = i;
    start_roll(4 * k + 1);
    wait_done(100);
    check("setup_face", face, 2);
    push_exp(1);
    roll = 1'b1;
    @(negedge clk);
    roll = 1'b0;
    check("pulse_spin_rolling", rolling, 1);
    check("pulse_spin_face", face, 2);
    @(negedge clk);
    check("pulse_slow_face", face, 2);
    check("pulse_slow_rolling", rolling, 1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("pulse_latency", n, 36);
    check("pulse_face", face, 5);
    repeat (3) @(negedge clk);

    // Keep rolling until the counter wraps back to zero
    while (model_cnt != 8'd0) begin
      start_roll($urandom_range(1, 12));
      wait_done(120);
    end
    @(negedge clk);
    check("wrap_count", roll_count, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
